snoop_resp_unit: RTL
====================

Name: snoop_resp_unit

Overview:
- Consumes the per-request outcome of the LLC snooped-read/snoop handler: snoop result (HIT/HITM/NOHIT) plus an optional GETLINE message to L1.
- Buffers outcomes in a small FIFO.
- Sequences each one onto three interfaces in a fixed order: L1 GETLINE handshake, bus snoop-result handshake, then bus writeback of the modified line for HITM.
- Sits between the snoop handler and the bus/L1 interfaces, and keeps saturating result counters for the statistics report.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- ADDR_W, 32, address width
- CNT_W, 16, width of each statistics counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  snoop handler has an outcome
- req_ready  out  1  FIFO can accept
- req_addr  in  ADDR_W  snooped address
- req_result  in  2  00 HIT, 01 HITM, 10 NOHIT, 11 illegal
- req_getline  in  1  GETLINE to L1 required
- l1_msg_valid  out  1  message to L1 pending
- l1_msg_type  out  3  001 GETLINE (only code this block issues)
- l1_msg_addr  out  ADDR_W  address for L1 message
- l1_msg_ack  in  1  L1 accepts message
- snp_valid  out  1  snoop result on bus
- snp_result  out  2  result code, same encoding as req_result
- snp_addr  out  ADDR_W  address for snoop result
- snp_ack  in  1  bus accepts result
- wb_valid  out  1  writeback of modified line requested
- wb_addr  out  ADDR_W  writeback address
- wb_ack  in  1  bus accepts writeback
- cnt_hit, cnt_hitm, cnt_nohit  out  CNT_W each  results delivered
- err  out  1  sticky protocol-error flag

Behaviour:
- Reset values:
  - all valids 0; req_ready 1 (after reset it tracks the registered FIFO count)
  - counters 0; err 0; FIFO empty; FSM IDLE
  - address outputs 0; l1_msg_type 000; snp_result 10 (NOHIT)
- Reset mid-operation aborts any in-flight handshake; the next cycle is the reset state.
- Push:
  - Occurs when req_valid && req_ready.
  - req_ready = !full, computed from the registered count.
  - A pop in the same cycle does not raise ready in that cycle.
  - A simultaneous push and pop both take effect and leave the count unchanged.
  - Pointers wrap modulo DEPTH.
- Sanitisation at push:
  - result 11 is stored as NOHIT and sets err.
  - getline with result ≠ HITM is stored as getline=0 and sets err.
- FSM states: IDLE, GETL, RESP, WB.
  - IDLE: if FIFO non-empty, pop into the entry register. Next state is GETL if getline=1, else RESP.
  - GETL: l1_msg_valid=1, type 001, addr = entry. Stay until l1_msg_ack, then RESP.
  - RESP: snp_valid=1, snp_result and snp_addr from entry. On snp_ack:
    - increment the matching counter
    - go to WB if result = HITM, else IDLE
  - WB: wb_valid=1, wb_addr = entry. On wb_ack, go to IDLE.
- Handshakes:
  - A valid, once raised, stays high with stable payload until its ack.
  - An ack arriving while the matching valid is low is ignored.
- All outputs are registered from state and entry; none depends combinationally on an ack.
- Latency, push accepted in cycle N with an empty FIFO and FSM in IDLE:
  - the entry pops at the end of N+1
  - the first valid (l1_msg_valid or snp_valid) is high in cycle N+2
  - one cycle later if an ack arrives the same cycle the valid first rises
- After a final ack, the FSM spends one IDLE cycle before the next entry's first valid (no back-to-back bypass).
- Counters saturate at all-ones and do not wrap.

Decomposition:
- Shared package cache_define holds:
  - snoop result enum: HIT=0, HITM=1, NOHIT=2
  - L1 message enum: GETLINE=1, SENDLINE=2, INVALIDATELINE=3, EVICTLINE=4
  - FSM state enum
  - entry struct {addr, result, getline}
- One sub-module: snoop_resp_fifo, a parameterised synchronous FIFO with count, full and empty flags.

Test Plan:
- Reset, then push {addr 0x0000_1040, HIT, getline 0}; ack snp on first assertion.
  - snp_valid high in cycle N+2 with result 00 and addr 0x1040
  - no l1_msg_valid or wb_valid
  - cnt_hit=1
- Push {0x0000_2080, HITM, getline 1}; delay l1_msg_ack 3 cycles, then ack snp and wb immediately.
  - order is GETLINE(001, 0x2080), then snp HITM, then wb_valid with 0x2080
  - every payload stays stable while its valid waits
  - cnt_hitm=1
- Hold snp_ack low, push 5 entries with DEPTH=4.
  - req_ready drops after 4 FIFO entries plus 1 entry in service
  - releasing acks drains all 5 in push order
- Push {0x3000, 11, 0} and {0x3040, HIT, 1}.
  - both delivered: the first as NOHIT, the second as HIT with no GETLINE
  - err=1 and stays sticky
- Assert rst mid-GETL with 2 entries queued.
  - the next cycle all valids are 0, the FIFO is empty, counters are 0 and req_ready=1
- With CNT_W=2, deliver 5 NOHIT results.
  - cnt_nohit reads 3 (saturated, no wrap)

Source files
------------

// File: rtl/cache_define.sv
// Shared LLC snoop definitions: result codes, L1 message codes, the
// response-sequencer states and the queued snoop-outcome entry.
package cache_define;

  // Width of the LLC physical address carried in a queued entry.
  localparam int unsigned CACHE_ADDR_W = 32;

  typedef enum logic [1:0] {
    SNP_HIT   = 2'd0,
    SNP_HITM  = 2'd1,
    SNP_NOHIT = 2'd2
  } snp_result_e;

  typedef enum logic [2:0] {
    L1_NONE           = 3'd0,
    L1_GETLINE        = 3'd1,
    L1_SENDLINE       = 3'd2,
    L1_INVALIDATELINE = 3'd3,
    L1_EVICTLINE      = 3'd4
  } l1_msg_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GETL = 2'd1,
    ST_RESP = 2'd2,
    ST_WB   = 2'd3
  } snp_state_e;

  typedef struct packed {
    logic [CACHE_ADDR_W-1:0] addr;
    snp_result_e             result;
    logic                    getline;
  } snp_entry_t;

  // Illegal result codes become NOHIT; a GETLINE only makes sense for HITM.
  function automatic snp_entry_t sanitize_entry(input logic [CACHE_ADDR_W-1:0] addr,
                                                input logic [1:0]              result,
                                                input logic                    getline);
    snp_entry_t e;
    e.addr    = addr;
    e.result  = (result == 2'b11) ? SNP_NOHIT : snp_result_e'(result);
    e.getline = getline && (e.result == SNP_HITM);
    return e;
  endfunction

  // True when the handler sent an outcome that needed sanitising.
  function automatic logic entry_illegal(input logic [1:0] result, input logic getline);
    return (result == 2'b11) || (getline && (result != 2'b01));
  endfunction

endpackage

// File: rtl/snoop_resp_fifo.sv
// Synchronous FIFO holding pending snoop outcomes. Full/empty come from the
// registered occupancy count, so neither depends on this cycle's push/pop.
module snoop_resp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int unsigned     PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [PTR_W:0]   CNT_ONE = 1;
  localparam logic [PTR_W:0]   CNT_MAX = DEPTH[PTR_W:0];

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_MAX);
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; only slots behind the write pointer are read.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/snoop_resp_unit.sv
// Snoop response sequencer: queues snoop-handler outcomes and plays each one
// out as L1 GETLINE -> bus snoop result -> bus writeback (HITM only), while
// keeping saturating per-result delivery counters and a sticky error flag.
// ADDR_W must equal cache_define::CACHE_ADDR_W (width of the queued entry).
module snoop_resp_unit
  import cache_define::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = CACHE_ADDR_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_result,
  input  logic              req_getline,
  output logic              l1_msg_valid,
  output logic [2:0]        l1_msg_type,
  output logic [ADDR_W-1:0] l1_msg_addr,
  input  logic              l1_msg_ack,
  output logic              snp_valid,
  output logic [1:0]        snp_result,
  output logic [ADDR_W-1:0] snp_addr,
  input  logic              snp_ack,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  input  logic              wb_ack,
  output logic [CNT_W-1:0]  cnt_hit,
  output logic [CNT_W-1:0]  cnt_hitm,
  output logic [CNT_W-1:0]  cnt_nohit,
  output logic              err
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  snp_state_e r_state;
  snp_entry_t r_entry;
  logic [CNT_W-1:0] r_cnt_hit;
  logic [CNT_W-1:0] r_cnt_hitm;
  logic [CNT_W-1:0] r_cnt_nohit;
  logic             r_err;

  snp_entry_t w_push_entry;
  snp_entry_t w_pop_entry;
  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic       w_resp_done;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  assign req_ready    = !w_full;
  assign w_push       = req_valid && !w_full;
  assign w_pop        = (r_state == ST_IDLE) && !w_empty;
  assign w_push_entry = sanitize_entry(req_addr, req_result, req_getline);
  assign w_resp_done  = (r_state == ST_RESP) && snp_ack;

  snoop_resp_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(snp_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_data  (w_pop_entry),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Sequencer: load an entry in IDLE, then walk GETL/RESP/WB on acks.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_entry <= '{addr: '0, result: SNP_NOHIT, getline: 1'b0};
    end else begin
      case (r_state)
        ST_IDLE: if (w_pop) begin
          r_entry <= w_pop_entry;
          r_state <= w_pop_entry.getline ? ST_GETL : ST_RESP;
        end
        ST_GETL: if (l1_msg_ack) r_state <= ST_RESP;
        ST_RESP: if (snp_ack) r_state <= (r_entry.result == SNP_HITM) ? ST_WB : ST_IDLE;
        ST_WB:   if (wb_ack) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Count each snoop result once the bus has accepted it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_hit   <= '0;
      r_cnt_hitm  <= '0;
      r_cnt_nohit <= '0;
    end else if (w_resp_done) begin
      case (r_entry.result)
        SNP_HIT:  r_cnt_hit   <= sat_inc(r_cnt_hit);
        SNP_HITM: r_cnt_hitm  <= sat_inc(r_cnt_hitm);
        default:  r_cnt_nohit <= sat_inc(r_cnt_nohit);
      endcase
    end
  end

  // Sticky flag for malformed outcomes seen at accepted pushes.
  always_ff @(posedge clk) begin
    if (rst) r_err <= 1'b0;
    else if (w_push && entry_illegal(req_result, req_getline)) r_err <= 1'b1;
  end

  assign l1_msg_valid = (r_state == ST_GETL);
  assign l1_msg_type  = l1_msg_valid ? L1_GETLINE : L1_NONE;
  assign l1_msg_addr  = r_entry.addr;
  assign snp_valid    = (r_state == ST_RESP);
  assign snp_result   = r_entry.result;
  assign snp_addr     = r_entry.addr;
  assign wb_valid     = (r_state == ST_WB);
  assign wb_addr      = r_entry.addr;
  assign cnt_hit      = r_cnt_hit;
  assign cnt_hitm     = r_cnt_hitm;
  assign cnt_nohit    = r_cnt_nohit;
  assign err          = r_err;

endmodule
